i2s_dac_tx: RTL and testbench

I2S_DAC_TX -- requirements
Module: i2s_dac_tx

---
 rtl/i2s_dac_tx.sv | 92 +++++++++
 tb/tb_i2s_dac_tx.sv | 299 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/i2s_dac_tx.sv
// Mono 16-bit sample to I2S serial frame transmitter (32 slots x 16 clocks, BCK = clk/16).
// Define I2S_PHILIPS_FORMAT_EN for Philips word-select timing; default is left-justified.
module i2s_dac_tx (
  input  logic        clk_27MHz,
  input  logic        reset,
  input  logic        clk_48kHz,
  input  logic [15:0] sample,
  output logic        i2s_bck,
  output logic        i2s_ws,
  output logic        i2s_dout,
  output logic        busy,
  output logic        overrun
);

  typedef enum logic {IDLE, SHIFT} state_t;

  state_t      state, state_nxt;
  logic        r1, r2;
  logic        start;
  logic        last_cycle;
  logic [15:0] hold;
  logic [3:0]  div;
  logic [4:0]  slot;

  // Synchroniser resets high so a clk_48kHz already high at release is not a start.
  // NOTE: sequential state uses non-blocking (<=) so every flop samples pre-edge values.
  always_ff @(posedge clk_27MHz) begin
    if (reset) begin
      r1 <= 1'b1;
      r2 <= 1'b1;
    end else begin
      r1 <= clk_48kHz;
      r2 <= r1;
    end
  end

  assign start      = r1 & ~r2;
  assign last_cycle = (slot == 5'd31) && (div == 4'd15);

  // NOTE: every always_comb output gets a default first, otherwise a latch is inferred.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = SHIFT;
      SHIFT:   if (last_cycle) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk_27MHz) begin
    if (reset) begin
      state   <= IDLE;
      hold    <= 16'h0000;
      div     <= 4'd0;
      slot    <= 5'd0;
      overrun <= 1'b0;
    end else begin
      state <= state_nxt;
      if (state == IDLE) begin
        if (start) begin
          hold <= sample;
          div  <= 4'd0;
          slot <= 5'd0;
        end
      end else begin
        // Slot counter wraps 31 -> 0 on the final cycle, leaving IDLE with clean counters.
        div <= div + 4'd1;
        if (div == 4'd15) slot <= slot + 5'd1;
        if (start) overrun <= 1'b1;
      end
    end
  end

  // Outputs decode directly from registered state, so they move only at slot or BCK edges.
  always_comb begin
    busy     = 1'b0;
    i2s_bck  = 1'b0;
    i2s_ws   = 1'b0;
    i2s_dout = 1'b0;
    if (state == SHIFT) begin
      busy     = 1'b1;
      i2s_bck  = div[3];
      i2s_dout = hold[~slot[3:0]];
`ifdef I2S_PHILIPS_FORMAT_EN
      i2s_ws   = (slot >= 5'd15) && (slot <= 5'd30);
`else
      i2s_ws   = slot[4];
`endif
    end
  end

endmodule

// File: tb/tb_i2s_dac_tx.sv
// Self-checking bench for i2s_dac_tx: expected per-slot ws/dout queued at each sample edge.
// Honours I2S_PHILIPS_FORMAT_EN to match the build under test.
`timescale 1ns/1ps
module tb_i2s_dac_tx;

  logic        clk_27MHz = 1'b0;
  logic        reset     = 1'b1;
  logic        clk_48kHz = 1'b0;
  logic [15:0] sample    = 16'h0000;
  logic        i2s_bck, i2s_ws, i2s_dout, busy, overrun;

  typedef struct packed {
    logic ws;
    logic dout;
  } slot_exp_t;

  slot_exp_t sb[$];
  int        total = 0;
  int        bad   = 0;
  int        cyc   = 0;
  int        rise_cyc = 0;

  i2s_dac_tx dut (
    .clk_27MHz (clk_27MHz),
    .reset     (reset),
    .clk_48kHz (clk_48kHz),
    .sample    (sample),
    .i2s_bck   (i2s_bck),
    .i2s_ws    (i2s_ws),
    .i2s_dout  (i2s_dout),
    .busy      (busy),
    .overrun   (overrun)
  );

  always #18 clk_27MHz = ~clk_27MHz;
  always @(posedge clk_27MHz) cyc <= cyc + 1;

  function automatic logic exp_ws(input int k);
`ifdef I2S_PHILIPS_FORMAT_EN
    return (k >= 15) && (k <= 30);
`else
    return k >= 16;
`endif
  endfunction

  task automatic push_frame(input logic [15:0] s);
    for (int k = 0; k < 32; k++) begin
      slot_exp_t e;
      e.ws   = exp_ws(k);
      e.dout = s[15 - (k % 16)];
      sb.push_back(e);
    end
  endtask

  // One clk_48kHz period starting with a rising edge; exact length when chained.
  task automatic gen_period(input logic [15:0] s, input int period, input bit push);
    @(negedge clk_27MHz);
    sample    = s;
    clk_48kHz = 1'b1;
    if (push) begin
      rise_cyc = cyc;
      push_frame(s);
    end
    repeat (period / 2) @(negedge clk_27MHz);
    clk_48kHz = 1'b0;
    repeat (period - period / 2 - 1) @(negedge clk_27MHz);
  endtask

  task automatic check_idle(input string name);
    total++;
    if ({busy, i2s_bck, i2s_ws, i2s_dout} !== 4'b0000) begin
      bad++;
      $display("FAIL %s: busy/bck/ws/dout=%b required 0000", name, {busy, i2s_bck, i2s_ws, i2s_dout});
    end
  endtask

  // Waits for a frame, checks latency, then every slot's 16 cycles against the scoreboard.
  task automatic monitor_frame(input string name);
    int waited = 0;
    while (busy !== 1'b1 && waited < 700) begin
      @(negedge clk_27MHz);
      waited++;
    end
    total++;
    if (busy !== 1'b1) begin
      bad++;
      $display("FAIL %s start: busy=%b required 1 within 700 cycles", name, busy);
      return;
    end
    total++;
    if (cyc - rise_cyc !== 2) begin
      bad++;
      $display("FAIL %s latency: got %0d cycles required 2", name, cyc - rise_cyc);
    end
    for (int s = 0; s < 32; s++) begin
      logic [15:0] oy, ob, ow, od;
      slot_exp_t   e;
      for (int c = 0; c < 16; c++) begin
        oy[c] = busy;
        ob[c] = i2s_bck;
        ow[c] = i2s_ws;
        od[c] = i2s_dout;
        @(negedge clk_27MHz);
      end
      total++;
      if (sb.size() == 0) begin
        bad++;
        $display("FAIL %s slot %0d: scoreboard empty", name, s);
      end else begin
        e = sb.pop_front();
        if ({oy, ob, ow, od} !== {16'hFFFF, 16'hFF00, {16{e.ws}}, {16{e.dout}}}) begin
          bad++;
          $display("FAIL %s slot %0d: busy/bck/ws/dout=%h/%h/%h/%h required ffff/ff00/%h/%h",
                   name, s, oy, ob, ow, od, {16{e.ws}}, {16{e.dout}});
        end
      end
    end
    check_idle({name, " end"});
  endtask

  task automatic check_overrun(input string name, input logic req);
    total++;
    if (overrun !== req) begin
      bad++;
      $display("FAIL %s: overrun=%b required %b", name, overrun, req);
    end
  endtask

  task automatic do_reset();
    @(negedge clk_27MHz);
    reset = 1'b1;
    repeat (3) @(negedge clk_27MHz);
    reset = 1'b0;
    sb.delete();
  endtask

  task automatic test_reset();
    reset     = 1'b1;
    clk_48kHz = 1'b1;
    repeat (4) @(negedge clk_27MHz);
    check_idle("reset_outputs");
    check_overrun("reset_overrun", 1'b0);
    reset = 1'b0;
    repeat (10) @(negedge clk_27MHz);
    check_idle("no_start_after_reset_high");
    clk_48kHz = 1'b0;
    repeat (10) @(negedge clk_27MHz);
  endtask

  task automatic test_basic();
    fork
      gen_period(16'hA5C3, 564, 1'b1);
      monitor_frame("basic_a5c3");
    join
  endtask

  task automatic test_back_to_back();
    fork
      begin
        gen_period(16'h8000, 564, 1'b1);
        gen_period(16'h7FFF, 564, 1'b1);
        gen_period(16'h0001, 564, 1'b1);
      end
      begin
        for (int f = 0; f < 3; f++) begin
          int idle = 0;
          monitor_frame($sformatf("b2b_frame%0d", f));
          if (f < 2) begin
            while (busy === 1'b0 && idle < 100) begin
              @(negedge clk_27MHz);
              idle++;
            end
            total++;
            if (idle !== 52) begin
              bad++;
              $display("FAIL b2b_idle%0d: got %0d idle cycles required 52", f, idle);
            end
          end
        end
      end
    join
    check_overrun("b2b_overrun", 1'b0);
  endtask

  task automatic test_sample_change();
    fork
      gen_period(16'h1234, 564, 1'b1);
      monitor_frame("sample_change");
      begin
        @(negedge clk_27MHz);
        repeat (82) @(negedge clk_27MHz);
        sample = 16'hFFFF;
      end
    join
  endtask

  task automatic test_overrun();
    fork
      begin
        gen_period(16'h3C5A, 300, 1'b1);
        gen_period(16'h0F0F, 300, 1'b0);
        gen_period(16'h9001, 564, 1'b1);
      end
      begin
        monitor_frame("overrun_frame1");
        check_overrun("overrun_after_frame1", 1'b1);
        monitor_frame("overrun_frame3");
        check_overrun("overrun_sticky", 1'b1);
      end
      begin
        @(negedge clk_27MHz);
        repeat (100) @(negedge clk_27MHz);
        check_overrun("overrun_before_edge", 1'b0);
      end
    join
  endtask

  task automatic test_boundary();
    int started = 0;
    do_reset();
    check_overrun("boundary_cleared", 1'b0);
    fork
      begin
        gen_period(16'hC001, 512, 1'b1);
        gen_period(16'h1111, 300, 1'b0);
      end
      begin
        monitor_frame("boundary_frame");
        for (int i = 0; i < 100; i++) begin
          if (busy !== 1'b0) started++;
          @(negedge clk_27MHz);
        end
        total++;
        if (started !== 0) begin
          bad++;
          $display("FAIL boundary_ignored: busy seen %0d cycles required 0", started);
        end
        check_overrun("boundary_overrun", 1'b1);
      end
    join
  endtask

  task automatic test_reset_mid_frame();
    int started = 0;
    @(negedge clk_27MHz);
    sample    = 16'h5555;
    clk_48kHz = 1'b1;
    repeat (2 + 160) @(negedge clk_27MHz);
    total++;
    if (busy !== 1'b1) begin
      bad++;
      $display("FAIL midreset_inframe: busy=%b required 1", busy);
    end
    reset = 1'b1;
    @(negedge clk_27MHz);
    check_idle("midreset_next_cycle");
    check_overrun("midreset_overrun", 1'b0);
    repeat (2) @(negedge clk_27MHz);
    reset = 1'b0;
    @(negedge clk_27MHz);
    check_idle("midreset_after_release");
    for (int i = 0; i < 100; i++) begin
      if (busy !== 1'b0) started++;
      @(negedge clk_27MHz);
    end
    total++;
    if (started !== 0) begin
      bad++;
      $display("FAIL midreset_no_restart: busy seen %0d cycles required 0", started);
    end
    clk_48kHz = 1'b0;
    repeat (20) @(negedge clk_27MHz);
    sb.delete();
    fork
      gen_period(16'h6A96, 564, 1'b1);
      monitor_frame("midreset_next_frame");
    join
  endtask

  initial begin
    test_reset();
    test_basic();
    test_back_to_back();
    test_sample_change();
    test_overrun();
    test_boundary();
    do_reset();
    test_reset_mid_frame();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #20ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
